// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: opcode encoding, FSM states and opcode helpers.
package serial_alu_pkg;

  typedef enum logic [2:0] {
    OP_PASSB = 3'b000,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } salu_state_t;

  // Only add/sub produce meaningful carry and overflow flags
  function automatic logic is_arith(input logic [2:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle between a sequencing controller and the serial ALU.
interface serial_alu_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       sel;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, A, B, sel,
    input  ready, busy, done, result, negative, zero, carry_out, overflow
  );

  modport slave (
    input  start, A, B, sel,
    output ready, busy, done, result, negative, zero, carry_out, overflow
  );
endinterface

// File: rtl/serial_alu_slice.sv
// Combinational SLICE-bit ripple slice: add/sub/and/or/xor/passB on one operand chunk.
module serial_alu_slice
  import serial_alu_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  output logic [SLICE-1:0] out,
  output logic             carryOut,
  output logic             msbCarryIn,
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic [2:0]       sel,
  input  logic             carryIn
);

  always_comb begin : p_ripple
    logic [SLICE:0] c;
    logic           bb;
    c          = '0;
    bb         = 1'b0;
    out        = '0;
    c[0]       = carryIn;
    for (int i = 0; i < int'(SLICE); i++) begin
      // Subtraction adds the inverted B with the initial carry supplied by the caller
      bb = (sel == OP_SUB) ? ~B[i] : B[i];
      case (sel)
        OP_ADD, OP_SUB: begin
          out[i]   = A[i] ^ bb ^ c[i];
          c[i+1]   = (A[i] & bb) | (c[i] & (A[i] ^ bb));
        end
        OP_AND:   out[i] = A[i] & B[i];
        OP_OR:    out[i] = A[i] | B[i];
        OP_XOR:   out[i] = A[i] ^ B[i];
        OP_PASSB: out[i] = B[i];
        default:  out[i] = 1'b0;
      endcase
    end
    carryOut   = c[SLICE];
    msbCarryIn = c[SLICE-1];
  end

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle ALU: one shared SLICE-bit slice walks WIDTH-bit operands LSB-first,
// with a start/ready/done handshake and registered result plus N/Z/C/V flags.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 8
) (
  input  logic         clk,
  input  logic         reset,
  serial_alu_if.slave  bus
);

  localparam int unsigned NPASS = WIDTH / SLICE;
  localparam int unsigned CW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("serial_alu: WIDTH must be a multiple of SLICE");
  end

  salu_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d, zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;

  logic [SLICE-1:0] s_out;
  logic             s_cout, s_msbcin;
  logic [WIDTH-1:0] s_ext;

  serial_alu_slice #(.SLICE(SLICE)) u_slice (
    .out        (s_out),
    .carryOut   (s_cout),
    .msbCarryIn (s_msbcin),
    .A          (a_q[SLICE-1:0]),
    .B          (b_q[SLICE-1:0]),
    .sel        (op_q),
    .carryIn    (carry_q)
  );

  // Slice output enters the accumulator from the top so the LSB chunk ends up lowest
  assign s_ext = WIDTH'(s_out) << (WIDTH - SLICE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.sel;
          cnt_d   = '0;
          carry_d = (bus.sel == OP_SUB);
        end
      end
      S_RUN: begin
        acc_d   = (acc_q >> SLICE) | s_ext;
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = s_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NPASS - 1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = acc_d;
          neg_d    = acc_d[WIDTH-1];
          zero_d   = (acc_d == '0);
          cout_d   = is_arith(op_q) & s_cout;
          ovf_d    = is_arith(op_q) & (s_cout ^ s_msbcin);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: three instances (SLICE 8, 64, 1) checked against an arithmetic model.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int unsigned W    = 64;
  localparam int          NDUT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic         start_v [NDUT];
  logic [W-1:0] a_v     [NDUT];
  logic [W-1:0] b_v     [NDUT];
  logic [2:0]   sel_v   [NDUT];
  logic         ready_v [NDUT];
  logic         busy_v  [NDUT];
  logic         done_v  [NDUT];
  logic [W-1:0] res_v   [NDUT];
  logic [3:0]   flg_v   [NDUT];

  logic         pend    [NDUT];
  logic [W-1:0] exp_res [NDUT];
  logic [3:0]   exp_flg [NDUT];
  int           acc_cyc [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned SL = (g == 0) ? 8 : ((g == 1) ? 64 : 1);
    serial_alu_if #(.WIDTH(W)) bus ();
    assign bus.start = start_v[g];
    assign bus.A     = a_v[g];
    assign bus.B     = b_v[g];
    assign bus.sel   = sel_v[g];
    assign ready_v[g] = bus.ready;
    assign busy_v[g]  = bus.busy;
    assign done_v[g]  = bus.done;
    assign res_v[g]   = bus.result;
    assign flg_v[g]   = {bus.negative, bus.zero, bus.carry_out, bus.overflow};
    serial_alu #(.WIDTH(W), .SLICE(SL)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  function automatic int npass_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 1 : 64);
  endfunction

  // Whole-word reference: {result, N, Z, C, V}
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] s);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c, v;
    r = '0; c = 1'b0; v = 1'b0; t = '0;
    case (s)
      3'b000: r = b;
      3'b010: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[W-1:0]; c = t[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b011: begin
        t = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = t[W-1:0]; c = t[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Compare process: judges every done pulse and the busy window before it
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (done_v[i]) begin
        if (!pend[i]) begin
          checks++; errors++;
          $display("FAIL d%0d_spurious_done: got done=1 expected done=0", i);
        end else begin
          check($sformatf("d%0d_result", i), res_v[i], exp_res[i]);
          check($sformatf("d%0d_flags_nzcv", i), W'(flg_v[i]), W'(exp_flg[i]));
          check($sformatf("d%0d_latency", i), W'(cyc - acc_cyc[i]), W'(npass_of(i)));
          pend[i] = 1'b0;
        end
      end else if (pend[i]) begin
        check($sformatf("d%0d_ready_busy", i), W'({ready_v[i], busy_v[i]}), W'(2'b01));
        if (cyc - acc_cyc[i] > npass_of(i)) begin
          checks++; errors++;
          $display("FAIL d%0d_done_timeout: got no done after %0d edges expected %0d",
                   i, cyc - acc_cyc[i], npass_of(i));
          pend[i] = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_v[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[i]) begin
      checks++; errors++;
      $display("FAIL d%0d_ready_timeout: got ready=0 expected ready=1", i);
      return;
    end
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; sel_v[i] = s;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    a_v[i] = {$urandom, $urandom};
    b_v[i] = {$urandom, $urandom};
    sel_v[i] = 3'($urandom_range(0, 7));
    acc_cyc[i] = cyc;
    {exp_res[i], exp_flg[i]} = model(a, b, s);
    pend[i] = 1'b1;
    n = 0;
    while (pend[i] && n < npass_of(i) + 6) begin
      @(negedge clk);
      n++;
    end
    if (pend[i]) begin
      checks++; errors++;
      $display("FAIL d%0d_op_wait: got pending after %0d cycles expected done", i, n);
      pend[i] = 1'b0;
    end
  endtask

  task automatic rand_op(input int i);
    logic [W-1:0] a, b;
    int mode;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    mode = $urandom_range(0, 5);
    if (mode == 0) b = a;
    else if (mode == 1) a = '1;
    else if (mode == 2) b = '1;
    do_op(i, a, b, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; sel_v[i] = '0;
      pend[i] = 1'b0; exp_res[i] = '0; exp_flg[i] = '0; acc_cyc[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d_rst_ctrl", i), W'({ready_v[i], busy_v[i], done_v[i]}), W'(3'b100));
      check($sformatf("d%0d_rst_result", i), res_v[i], '0);
      check($sformatf("d%0d_rst_flags", i), W'(flg_v[i]), '0);
    end

    // All-ones + 1 on every slice width
    for (int i = 0; i < NDUT; i++) begin
      do_op(i, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
      check($sformatf("d%0d_t1_result", i), res_v[i], 64'h0);
      check($sformatf("d%0d_t1_flags", i), W'(flg_v[i]), W'(4'b0110));
    end

    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 3'b011);
    check("t2_sub_result", res_v[0], 64'h7FFF_FFFF_FFFF_FFFF);
    check("t2_sub_flags", W'(flg_v[0]), W'(4'b0011));

    do_op(0, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, 3'b110);
    check("t3_xor_result", res_v[0], 64'hFF00_0000_0000_0FF0);
    check("t3_xor_flags", W'(flg_v[0]), W'(4'b1000));
    do_op(0, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, 3'b100);
    check("t3_and_result", res_v[0], 64'h00F0_0000_0000_000F);
    check("t3_and_flags", W'(flg_v[0]), W'(4'b0000));
    do_op(0, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, 3'b101);
    check("t3_or_result", res_v[0], 64'hFFF0_0000_0000_0FFF);
    check("t3_or_flags", W'(flg_v[0]), W'(4'b1000));

    // Extra start pulses in RUN cycles 2..5 must be ignored
    fork
      do_op(0, 64'd100, 64'd23, 3'b010);
      begin
        wait (pend[0] == 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          start_v[0] = 1'b1;
          a_v[0] = {$urandom, $urandom};
          b_v[0] = {$urandom, $urandom};
          sel_v[0] = 3'b011;
          @(negedge clk);
        end
        start_v[0] = 1'b0;
      end
    join
    check("t4_result", res_v[0], 64'd123);
    repeat (12) @(negedge clk);
    check("t4_idle_after", W'({ready_v[0], busy_v[0], done_v[0]}), W'(3'b100));

    // Reset during pass 4 clears outputs without waiting for a clock edge
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 64'h1234_5678_9ABC_DEF0; b_v[0] = 64'd5; sel_v[0] = 3'b010;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_ctrl", W'({ready_v[0], busy_v[0], done_v[0]}), W'(3'b100));
    check("t5_rst_result", res_v[0], '0);
    check("t5_rst_flags", W'(flg_v[0]), '0);
    @(negedge clk);
    reset = 1'b0;
    do_op(0, 64'd3, 64'd4, 3'b010);
    check("t5_after_result", res_v[0], 64'd7);
    check("t5_after_flags", W'(flg_v[0]), W'(4'b0000));

    fork
      begin for (int k = 0; k < 1000; k++) rand_op(0); end
      begin for (int k = 0; k < 1000; k++) rand_op(1); end
      begin for (int k = 0; k < 400;  k++) rand_op(2); end
    join

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
